cu_microsequencer: RTL and testbench
====================================

# cu_microsequencer

Microcode sequencer for the CPU control unit. It holds the micro-program counter, addresses the external microcode ROM, and drives the 59-bit control word that the control-signal field mapper splits into datapath selects and enables. The advance field (`cs_cu_adv_sel`, bits [29:28] of each word) selects the next micro-address: sequential, opcode dispatch, end-of-instruction with interrupt check, or halt.

## Interface
- `CW_WIDTH`, 59: control word width.
- `UADDR_WIDTH`, 10: micro-address width.
- `ADV_LSB`, 28: LSB of the 2-bit advance field in the control word.
- `FETCH_ADDR`, 0: micro-address of the instruction fetch routine.
- `IRQ_ADDR`, 16: micro-address of the interrupt entry routine.
- `DISPATCH_BASE`, 256: base of the opcode dispatch table; one entry per opcode.
- `IDLE_WORD`, 59'h0000_0000_4000_0004: inactive control word. Bit 30 (`db_nread`) and bit 2 (`db_nwrite`) are high; all other bits are 0.
- `clock` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high.
- `stall` input 1: bus wait; freezes the sequencer.
- `opcode` input 8: current instruction buffer contents.
- `irq_req` input 1: level, at least one enabled interrupt pending.
- `ime` input 1: interrupt master enable.
- `urom_addr` output UADDR_WIDTH: ROM address; equals uPC, combinational.
- `urom_data` input CW_WIDTH: ROM word at `urom_addr`, combinational, same cycle.
- `control_signals` output CW_WIDTH: control word to the field mapper.
- `irq_ack` output 1: one-cycle pulse when interrupt entry is taken.
- `instr_done` output 1: one-cycle pulse when an instruction retires.
- `halted` output 1: high while in HALT.

## Operation
- State machine states: RUN and HALT. uPC register is UADDR_WIDTH bits.
- Reset (`reset`=1 at an edge):
  - Next state is RUN, uPC is FETCH_ADDR.
  - `irq_ack`, `instr_done` and `halted` are 0.
  - While `reset` is high, `control_signals` is IDLE_WORD.
- RUN with `stall`=1:
  - uPC holds and state holds.
  - `control_signals` is IDLE_WORD; `irq_ack` and `instr_done` are 0.
- RUN with `stall`=0:
  - `control_signals` equals `urom_data`.
  - adv = `urom_data[ADV_LSB+1:ADV_LSB]`.
  - adv=0, NEXT: uPC ← uPC+1, mod 2^UADDR_WIDTH. All-ones wraps to 0.
  - adv=1, DISPATCH: uPC ← (DISPATCH_BASE + `opcode`) mod 2^UADDR_WIDTH. Uses the `opcode` value sampled in this cycle.
  - adv=2, END: `instr_done`=1 this cycle.
    - If `irq_req`&`ime`: uPC ← IRQ_ADDR and `irq_ack`=1 this cycle.
    - Otherwise uPC ← FETCH_ADDR.
  - adv=3, HALT: `instr_done`=1 this cycle; uPC ← FETCH_ADDR; state ← HALT.
- HALT:
  - `control_signals` is IDLE_WORD and `halted`=1.
  - `stall` is ignored.
  - `irq_req`=0: remain in HALT.
  - `irq_req`=1 and `ime`=1: state ← RUN, uPC ← IRQ_ADDR, `irq_ack`=1 this cycle.
  - `irq_req`=1 and `ime`=0: state ← RUN, uPC ← FETCH_ADDR, `irq_ack`=0.
- Priority: `reset` > `stall` (RUN only) > advance decode.
- `irq_ack` is asserted only on the cycle the uPC←IRQ_ADDR transfer is decided, never otherwise.

## Timing
- Zero-latency path from `urom_data` to `control_signals` and to the next-uPC logic. `urom_addr` is registered uPC.
- Each non-stalled RUN cycle executes exactly one micro-word. The next word appears on the cycle after the edge.
- END→fetch: the first fetch word is executed on the cycle immediately after the END word, with no bubble.
- HALT wake: the first RUN word executes on the cycle after the edge that samples `irq_req`=1.
- A stall of N cycles delays execution by exactly N cycles. The word under stall is re-presented unchanged when `stall` drops.
- Reset deasserted at edge k: the word at FETCH_ADDR drives `control_signals` in cycle k.
- All pulse outputs are combinational within the deciding cycle. They are registered by the consumer.

## Test plan
- Reset then sequential run:
  - Stimulus: ROM[0..2] adv=0,0,2, `irq_req`=0.
  - Response: `urom_addr` goes 0,1,2,0. `instr_done` pulses on the word at address 2. `control_signals` equals each ROM word. During `reset`, `control_signals`=0x40000004.
- Dispatch:
  - Stimulus: `opcode`=0x3E, word adv=1.
  - Response: next `urom_addr`=256+0x3E=318. With `opcode`=0xFF, next `urom_addr`=511.
  - Wrap: word at 1023 with adv=0 → next address 0.
- Interrupt at END:
  - Stimulus: `irq_req`=1, `ime`=1, END word.
  - Response: `irq_ack` and `instr_done` pulse together; next `urom_addr`=16.
  - With `ime`=0: next `urom_addr`=0 and no ack.
- Stall:
  - Stimulus: `stall`=1 for 3 cycles on address 5.
  - Response: `urom_addr` stays 5, `control_signals`=IDLE_WORD, no pulses. After release, the address-5 word is output once, then 6.
  - Stall on an END word with `irq_req`=1: no `irq_ack` until the stall ends.
- HALT:
  - Stimulus: adv=3 word.
  - Response: `halted`=1 and IDLE_WORD output. `stall` toggling has no effect.
  - `irq_req`=1, `ime`=0 → RUN at 0 with no ack.
  - Repeat with `ime`=1 → RUN at 16 with `irq_ack` pulse.
  - `reset` asserted in HALT → RUN at 0, `halted`=0.

Source files
------------

// File: rtl/cu_microsequencer.sv
`default_nettype none
// ============================================================================
// Module   : cu_microsequencer
// Purpose  : Microcode sequencer for the CPU control unit. Holds the
//            micro-program counter (uPC), addresses the external microcode
//            ROM and forwards the fetched control word to the field mapper.
//            The 2-bit advance field of each word picks the next uPC:
//              0 NEXT     : uPC + 1 (wraps)
//              1 DISPATCH : DISPATCH_BASE + opcode
//              2 END      : retire; go to IRQ_ADDR if an interrupt is
//                           accepted, otherwise FETCH_ADDR
//              3 HALT     : retire; go to FETCH_ADDR and park in HALT
// Ports    : clock           - single clock, rising edge
//            reset           - synchronous, active-high
//            stall           - bus wait, freezes the sequencer in RUN
//            opcode          - instruction buffer contents (dispatch index)
//            irq_req         - level, an enabled interrupt is pending
//            ime             - interrupt master enable
//            urom_addr       - ROM address (registered uPC)
//            urom_data       - ROM word at urom_addr, same cycle
//            control_signals - control word to the field mapper
//            irq_ack         - pulse when interrupt entry is taken
//            instr_done      - pulse when an instruction retires
//            halted          - high while parked in HALT
// Revision : 1.0 - initial release
// ============================================================================
module cu_microsequencer #(
  parameter int                  CW_WIDTH      = 59,
  parameter int                  UADDR_WIDTH   = 10,
  parameter int                  ADV_LSB       = 28,
  parameter int                  FETCH_ADDR    = 0,
  parameter int                  IRQ_ADDR      = 16,
  parameter int                  DISPATCH_BASE = 256,
  parameter logic [CW_WIDTH-1:0] IDLE_WORD     = 59'h0000_0000_4000_0004
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   stall,
  input  logic [7:0]             opcode,
  input  logic                   irq_req,
  input  logic                   ime,
  output logic [UADDR_WIDTH-1:0] urom_addr,
  input  logic [CW_WIDTH-1:0]    urom_data,
  output logic [CW_WIDTH-1:0]    control_signals,
  output logic                   irq_ack,
  output logic                   instr_done,
  output logic                   halted
);

  // Fixed micro-addresses, truncated to the uPC width so that every
  // next-address computation is naturally modulo 2^UADDR_WIDTH.
  localparam logic [UADDR_WIDTH-1:0] c_fetch_addr    = UADDR_WIDTH'(FETCH_ADDR);
  localparam logic [UADDR_WIDTH-1:0] c_irq_addr      = UADDR_WIDTH'(IRQ_ADDR);
  localparam logic [UADDR_WIDTH-1:0] c_dispatch_base = UADDR_WIDTH'(DISPATCH_BASE);
  localparam logic [UADDR_WIDTH-1:0] c_one           = UADDR_WIDTH'(1);

  // Advance field encodings.
  localparam logic [1:0] c_adv_next     = 2'd0;
  localparam logic [1:0] c_adv_dispatch = 2'd1;
  localparam logic [1:0] c_adv_end      = 2'd2;
  localparam logic [1:0] c_adv_halt     = 2'd3;

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [UADDR_WIDTH-1:0] r_upc;
  logic [UADDR_WIDTH-1:0] w_upc_nxt;
  logic [1:0]             w_adv;
  logic [UADDR_WIDTH-1:0] w_upc_inc;
  logic [UADDR_WIDTH-1:0] w_dispatch_addr;
  logic                   w_irq_take;

  assign urom_addr       = r_upc;
  assign w_adv           = urom_data[ADV_LSB +: 2];
  assign w_upc_inc       = r_upc + c_one;
  assign w_dispatch_addr = c_dispatch_base + UADDR_WIDTH'(opcode);
  assign w_irq_take      = irq_req & ime;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_RUN;
      r_upc   <= c_fetch_addr;
    end else begin
      r_state <= w_state_nxt;
      r_upc   <= w_upc_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state / output decode
  // The ROM word passes straight through to control_signals and into the
  // next-uPC mux in the same cycle; every inactive case (reset, stall, HALT)
  // presents IDLE_WORD so the datapath never sees a half-executed word.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt     = r_state;
    w_upc_nxt       = r_upc;
    control_signals = IDLE_WORD;
    irq_ack         = 1'b0;
    instr_done      = 1'b0;
    halted          = 1'b0;

    if (!reset) begin
      case (r_state)
        ST_RUN: begin
          // A stalled word is held and re-presented unchanged; END side
          // effects such as irq_ack are deferred until the stall drops.
          if (!stall) begin
            control_signals = urom_data;
            case (w_adv)
              c_adv_next: begin
                w_upc_nxt = w_upc_inc;
              end
              c_adv_dispatch: begin
                w_upc_nxt = w_dispatch_addr;
              end
              c_adv_end: begin
                instr_done = 1'b1;
                if (w_irq_take) begin
                  w_upc_nxt = c_irq_addr;
                  irq_ack   = 1'b1;
                end else begin
                  w_upc_nxt = c_fetch_addr;
                end
              end
              c_adv_halt: begin
                instr_done  = 1'b1;
                w_upc_nxt   = c_fetch_addr;
                w_state_nxt = ST_HALT;
              end
              default: begin
                w_upc_nxt = r_upc;
              end
            endcase
          end
        end

        ST_HALT: begin
          // Any pending interrupt wakes the core; only an enabled one
          // vectors to the interrupt routine, otherwise execution resumes
          // at the fetch routine.
          halted = 1'b1;
          if (irq_req) begin
            w_state_nxt = ST_RUN;
            if (ime) begin
              w_upc_nxt = c_irq_addr;
              irq_ack   = 1'b1;
            end else begin
              w_upc_nxt = c_fetch_addr;
            end
          end
        end

        default: begin
          w_state_nxt = ST_RUN;
          w_upc_nxt   = c_fetch_addr;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cu_microsequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_cu_microsequencer
// Purpose  : Self-checking bench for cu_microsequencer. A directed vector
//            table walks the sequential, dispatch, interrupt, stall and HALT
//            scenarios, a hand-written loop exercises uPC wrap, and a random
//            phase compares against a behavioural model of the sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cu_microsequencer;

  localparam int          c_cw    = 59;
  localparam int          c_aw    = 10;
  localparam int          c_depth = 1024;
  localparam logic [58:0] c_idle  = 59'h0000_0000_4000_0004;

  logic            clock;
  logic            reset;
  logic            stall;
  logic [7:0]      opcode;
  logic            irq_req;
  logic            ime;
  logic [c_aw-1:0] urom_addr;
  logic [c_cw-1:0] urom_data;
  logic [c_cw-1:0] control_signals;
  logic            irq_ack;
  logic            instr_done;
  logic            halted;

  logic [c_cw-1:0] rom [c_depth];

  int n_chk;
  int n_fail;

  cu_microsequencer dut (
    .clock           (clock),
    .reset           (reset),
    .stall           (stall),
    .opcode          (opcode),
    .irq_req         (irq_req),
    .ime             (ime),
    .urom_addr       (urom_addr),
    .urom_data       (urom_data),
    .control_signals (control_signals),
    .irq_ack         (irq_ack),
    .instr_done      (instr_done),
    .halted          (halted)
  );

  assign urom_data = rom[urom_addr];

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    logic       rst;
    logic       stl;
    logic [7:0] opc;
    logic       irq;
    logic       en;
    int         addr;
    logic       cs_rom;
    logic       ack;
    logic       done;
    logic       hlt;
  } vec_t;

  vec_t tbl [36];

  function automatic vec_t v(input logic rst, input logic stl, input logic [7:0] opc,
                             input logic irq, input logic en, input int addr,
                             input logic cs_rom, input logic ack, input logic done,
                             input logic hlt);
    vec_t r;
    r.rst = rst; r.stl = stl; r.opc = opc; r.irq = irq; r.en = en;
    r.addr = addr; r.cs_rom = cs_rom; r.ack = ack; r.done = done; r.hlt = hlt;
    return r;
  endfunction

  // Tagged ROM word: tag in high and low bits, advance code at [29:28].
  function automatic logic [58:0] mk(input int adv, input int tag);
    logic [63:0] w;
    w = (64'(tag) << 40) | (64'(adv & 3) << 28) | 64'(tag & 32'hFFF);
    return w[58:0];
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Drive one cycle's inputs (called just after a rising edge) and move to
  // the falling edge where outputs are sampled.
  task automatic apply(input logic rst, input logic stl, input logic [7:0] opc,
                       input logic irq, input logic en);
    reset   = rst;
    stall   = stl;
    opcode  = opc;
    irq_req = irq;
    ime     = en;
    #4;
  endtask

  task automatic adv_clk();
    @(posedge clock);
    #1;
  endtask

  // Behavioural model state
  int          m_pc;
  bit          m_halt;
  int          e_pc;
  bit          e_halt;
  logic [58:0] e_cs;
  bit          e_ack;
  bit          e_done;
  bit          e_hlt;

  task automatic model_step(input bit rst, input bit stl, input int opc,
                            input bit irq, input bit en);
    int adv;
    logic [58:0] w;
    e_cs = c_idle; e_ack = 0; e_done = 0; e_hlt = 0;
    e_pc = m_pc; e_halt = m_halt;
    if (rst) begin
      e_pc = 0; e_halt = 0;
    end else if (m_halt) begin
      e_hlt = 1;
      if (irq) begin
        e_halt = 0;
        e_ack  = en;
        e_pc   = en ? 16 : 0;
      end
    end else if (!stl) begin
      w    = rom[m_pc];
      e_cs = w;
      adv  = int'((w >> 28) & 59'd3);
      if (adv == 0) e_pc = (m_pc + 1) % c_depth;
      else if (adv == 1) e_pc = (256 + opc) % c_depth;
      else if (adv == 2) begin
        e_done = 1;
        if (irq && en) begin e_ack = 1; e_pc = 16; end
        else e_pc = 0;
      end else begin
        e_done = 1; e_pc = 0; e_halt = 1;
      end
    end
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;

    for (int i = 0; i < c_depth; i++) rom[i] = mk(0, i + 1);
    rom[2]   = mk(2, 3);
    rom[17]  = mk(1, 18);
    rom[318] = mk(2, 319);
    rom[511] = mk(3, 512);

    //           rst stl opc    irq en  addr rom ack dn hlt
    tbl[0]  = v(1, 0, 8'h00, 0, 0,   0, 0, 0, 0, 0);
    tbl[1]  = v(0, 0, 8'h00, 0, 0,   0, 1, 0, 0, 0);
    tbl[2]  = v(0, 0, 8'h00, 0, 0,   1, 1, 0, 0, 0);
    tbl[3]  = v(0, 0, 8'h00, 0, 0,   2, 1, 0, 1, 0);
    tbl[4]  = v(0, 0, 8'h00, 0, 0,   0, 1, 0, 0, 0);
    tbl[5]  = v(0, 0, 8'h00, 0, 0,   1, 1, 0, 0, 0);
    tbl[6]  = v(0, 0, 8'h00, 1, 1,   2, 1, 1, 1, 0);
    tbl[7]  = v(0, 0, 8'h00, 0, 0,  16, 1, 0, 0, 0);
    tbl[8]  = v(0, 0, 8'h3E, 0, 0,  17, 1, 0, 0, 0);
    tbl[9]  = v(0, 0, 8'h00, 1, 0, 318, 1, 0, 1, 0);
    tbl[10] = v(0, 0, 8'h00, 0, 0,   0, 1, 0, 0, 0);
    tbl[11] = v(0, 0, 8'h00, 0, 0,   1, 1, 0, 0, 0);
    tbl[12] = v(0, 1, 8'h00, 1, 1,   2, 0, 0, 0, 0);
    tbl[13] = v(0, 1, 8'h00, 1, 1,   2, 0, 0, 0, 0);
    tbl[14] = v(0, 1, 8'h00, 1, 1,   2, 0, 0, 0, 0);
    tbl[15] = v(0, 0, 8'h00, 1, 1,   2, 1, 1, 1, 0);
    tbl[16] = v(0, 0, 8'h00, 0, 0,  16, 1, 0, 0, 0);
    tbl[17] = v(0, 0, 8'hFF, 0, 0,  17, 1, 0, 0, 0);
    tbl[18] = v(0, 0, 8'h00, 0, 0, 511, 1, 0, 1, 0);
    tbl[19] = v(0, 1, 8'h00, 0, 0,   0, 0, 0, 0, 1);
    tbl[20] = v(0, 0, 8'h00, 0, 1,   0, 0, 0, 0, 1);
    tbl[21] = v(0, 1, 8'h00, 1, 0,   0, 0, 0, 0, 1);
    tbl[22] = v(0, 0, 8'h00, 0, 0,   0, 1, 0, 0, 0);
    tbl[23] = v(0, 0, 8'h00, 0, 0,   1, 1, 0, 0, 0);
    tbl[24] = v(0, 0, 8'h00, 1, 1,   2, 1, 1, 1, 0);
    tbl[25] = v(0, 0, 8'h00, 0, 0,  16, 1, 0, 0, 0);
    tbl[26] = v(0, 0, 8'hFF, 0, 0,  17, 1, 0, 0, 0);
    tbl[27] = v(0, 0, 8'h00, 0, 0, 511, 1, 0, 1, 0);
    tbl[28] = v(0, 1, 8'h00, 0, 1,   0, 0, 0, 0, 1);
    tbl[29] = v(0, 0, 8'h00, 1, 1,   0, 0, 1, 0, 1);
    tbl[30] = v(0, 0, 8'h00, 0, 0,  16, 1, 0, 0, 0);
    tbl[31] = v(0, 0, 8'hFF, 0, 0,  17, 1, 0, 0, 0);
    tbl[32] = v(0, 0, 8'h00, 0, 0, 511, 1, 0, 1, 0);
    tbl[33] = v(0, 0, 8'h00, 0, 0,   0, 0, 0, 0, 1);
    tbl[34] = v(1, 0, 8'h00, 0, 0,   0, 0, 0, 0, 0);
    tbl[35] = v(0, 0, 8'h00, 0, 0,   0, 1, 0, 0, 0);

    // Initial reset so the uPC is defined before the table starts.
    reset = 1'b1; stall = 1'b0; opcode = 8'h00; irq_req = 1'b0; ime = 1'b0;
    adv_clk();

    for (int i = 0; i < 36; i++) begin
      logic [58:0] exp_cs;
      apply(tbl[i].rst, tbl[i].stl, tbl[i].opc, tbl[i].irq, tbl[i].en);
      exp_cs = tbl[i].cs_rom ? rom[tbl[i].addr] : c_idle;
      chk($sformatf("vec%0d urom_addr", i), 64'(urom_addr), 64'(tbl[i].addr));
      chk($sformatf("vec%0d control_signals", i), 64'(control_signals), 64'(exp_cs));
      chk($sformatf("vec%0d irq_ack", i), 64'(irq_ack), 64'(tbl[i].ack));
      chk($sformatf("vec%0d instr_done", i), 64'(instr_done), 64'(tbl[i].done));
      chk($sformatf("vec%0d halted", i), 64'(halted), 64'(tbl[i].hlt));
      adv_clk();
    end

    // Wrap: route through dispatch to 511 and count up through 1023 to 0.
    rom[511] = mk(0, 512);
    apply(0, 0, 8'h00, 0, 0);
    chk("wrap pre addr1", 64'(urom_addr), 64'd1);
    adv_clk();
    apply(0, 0, 8'h00, 1, 1);
    chk("wrap pre addr2", 64'(urom_addr), 64'd2);
    adv_clk();
    apply(0, 0, 8'h00, 0, 0);
    chk("wrap pre addr16", 64'(urom_addr), 64'd16);
    adv_clk();
    apply(0, 0, 8'hFF, 0, 0);
    chk("wrap pre addr17", 64'(urom_addr), 64'd17);
    adv_clk();
    for (int a = 511; a < c_depth; a++) begin
      apply(0, 0, 8'h00, 0, 0);
      chk($sformatf("seq addr %0d", a), 64'(urom_addr), 64'(a));
      adv_clk();
    end
    apply(0, 0, 8'h00, 0, 0);
    chk("wrap 1023->0", 64'(urom_addr), 64'd0);
    chk("wrap cs", 64'(control_signals), 64'(rom[0]));
    adv_clk();

    // Random phase against the behavioural model. The last word executed
    // was at address 0 (NEXT), so the uPC now holds 1 in RUN.
    m_pc = 1; m_halt = 0;
    for (int i = 0; i < c_depth; i++) begin
      logic [63:0] w;
      int adv_pick;
      w = {$urandom, $urandom};
      adv_pick = $urandom_range(0, 9);
      w[29:28] = (adv_pick < 6) ? 2'd0 : (adv_pick < 8) ? 2'd1 : (adv_pick == 8) ? 2'd2 : 2'd3;
      rom[i] = w[58:0];
    end
    for (int c = 0; c < 3000; c++) begin
      bit rr, ss, ii, ee;
      int oo;
      rr = ($urandom_range(0, 49) == 0);
      ss = ($urandom_range(0, 3) == 0);
      ii = ($urandom_range(0, 9) < 3);
      ee = $urandom_range(0, 1) == 1;
      oo = $urandom_range(0, 255);
      apply(rr, ss, 8'(oo), ii, ee);
      model_step(rr, ss, oo, ii, ee);
      chk("rnd urom_addr", 64'(urom_addr), 64'(m_pc));
      chk("rnd control_signals", 64'(control_signals), 64'(e_cs));
      chk("rnd irq_ack", 64'(irq_ack), 64'(e_ack));
      chk("rnd instr_done", 64'(instr_done), 64'(e_done));
      chk("rnd halted", 64'(halted), 64'(e_hlt));
      m_pc   = e_pc;
      m_halt = e_halt;
      adv_clk();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
